// File: rtl/fetch_ctrl_pkg.sv
`ifndef FETCH_CTRL_PKG_SV
`define FETCH_CTRL_PKG_SV
`default_nettype none
// +--------------------------------------------------------------+
// | fetch_ctrl_pkg : cpu-wide fetch defaults  (rev 1.0)           |
// +--------------------------------------------------------------+
package fetch_ctrl_pkg;
  localparam int unsigned DEF_ADDR_W   = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int unsigned INST_W       = 32;
endpackage
`default_nettype wire
`endif

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------+
// | fetch_ctrl_if : imem / decode / redirect bundle  (rev 1.0)    |
// +--------------------------------------------------------------+
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
);
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              busy;

  modport master (
    output imem_addr,
    input  imem_data,
    output inst_valid,
    input  inst_ready,
    output inst_out,
    output inst_pc,
    input  redirect_valid,
    input  redirect_pc,
    input  halt,
    output busy
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  inst_valid,
    output inst_ready,
    input  inst_out,
    input  inst_pc,
    output redirect_valid,
    output redirect_pc,
    output halt,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------+
// | fetch_ctrl : PC sequencer with replay and redirect flush      |
// | rev 1.0                                                       |
// +--------------------------------------------------------------+
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fetch_ctrl_if.master bus
);

  logic [ADDR_W-1:0] fetch_pc_q,   fetch_pc_d;
  logic              pend_q,       pend_d;
  logic [ADDR_W-1:0] pend_pc_q,    pend_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic [INST_W-1:0] inst_out_q,   inst_out_d;
  logic [ADDR_W-1:0] inst_pc_q,    inst_pc_d;
  logic              w_accept;

  assign w_accept = pend_q && (!inst_valid_q || bus.inst_ready);

  // A blocked word keeps its address on the bus so memory re-presents it.
  assign bus.imem_addr  = (pend_q && !w_accept) ? pend_pc_q : fetch_pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_out   = inst_out_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.busy       = pend_q || inst_valid_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pend_d       = pend_q;
    pend_pc_d    = pend_pc_q;
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d   = bus.redirect_pc;
      pend_d       = 1'b0;
      inst_valid_d = 1'b0;
    end else begin
      if (w_accept) begin
        inst_valid_d = 1'b1;
        inst_out_d   = bus.imem_data;
        inst_pc_d    = pend_pc_q;
      end else if (inst_valid_q && bus.inst_ready) begin
        inst_valid_d = 1'b0;
      end

      if (pend_q && !w_accept) begin
        pend_d = 1'b1;
      end else if (!bus.halt) begin
        pend_d     = 1'b1;
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 1'b1;
      end else begin
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      pend_q       <= 1'b0;
      pend_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pend_q       <= pend_d;
      pend_pc_q    <= pend_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_fetch_ctrl : vectors, random scoreboard, corner sequences  |
// | rev 1.0                                                       |
// +--------------------------------------------------------------+
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.ADDR_W(32)) bus ();
  fetch_ctrl_if #(.ADDR_W(4))  bus4 ();

  fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  fetch_ctrl #(.ADDR_W(4),  .RESET_PC(4'd3))  u_dut4 (.clk(clk), .rst(rst4), .bus(bus4));

  function automatic logic [31:0] word_of(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0000_0000;
      32'd1:   return 32'h3402_0026;
      32'd2:   return 32'h3403_0034;
      32'd3:   return 32'h0062_8020;
      32'd4:   return 32'hae02_0001;
      default: return (a * 32'h9E37_79B9) + 32'h0000_1357;
    endcase
  endfunction

  always @(posedge clk) bus.imem_data  <= word_of(bus.imem_addr);
  always @(posedge clk) bus4.imem_data <= word_of({28'd0, bus4.imem_addr});

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        halt;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_out;
    logic        e_busy;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[15];

  typedef struct {
    logic [31:0] pc;
    bit          cap;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_next;

  task automatic drive(input logic rdy, input logic rd, input logic [31:0] rpc, input logic h);
    bus.inst_ready     = rdy;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    bus.halt           = h;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic b);
    chk({tag, " valid"}, {31'd0, bus.inst_valid}, {31'd0, v});
    chk({tag, " busy"},  {31'd0, bus.busy},       {31'd0, b});
    if (v) begin
      chk({tag, " pc"},  bus.inst_pc,  pc);
      chk({tag, " out"}, bus.inst_out, word_of(pc));
    end
  endtask

  initial begin
    logic        r, rd, h;
    logic [31:0] rpc, e_addr;
    bit          has_buf, has_pend;

    vecs[0]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0,         1'b0, 32'd0};
    vecs[1]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0,         1'b1, 32'd1};
    vecs[2]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 32'h0000_0000, 1'b1, 32'd2};
    vecs[3]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'd1, 32'h3402_0026, 1'b1, 32'd2};
    vecs[4]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'd1, 32'h3402_0026, 1'b1, 32'd2};
    vecs[5]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'd1, 32'h3402_0026, 1'b1, 32'd2};
    vecs[6]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd1, 32'h3402_0026, 1'b1, 32'd3};
    vecs[7]  = '{1'b1, 1'b1, 32'd4, 1'b0, 1'b1, 32'd2, 32'h3403_0034, 1'b1, 32'd4};
    vecs[8]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0,         1'b0, 32'd4};
    vecs[9]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0,         1'b1, 32'd5};
    vecs[10] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd4, 32'hae02_0001, 1'b1, 32'd6};
    vecs[11] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd5, word_of(32'd5), 1'b1, 32'd6};
    vecs[12] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0,         1'b0, 32'd6};
    vecs[13] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0,         1'b1, 32'd7};
    vecs[14] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd6, word_of(32'd6), 1'b1, 32'd8};

    drive(1'b1, 1'b0, 32'd0, 1'b0);
    bus4.inst_ready = 1'b1; bus4.redirect_valid = 1'b0; bus4.redirect_pc = 4'd0; bus4.halt = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("reset out",   bus.inst_out,            32'd0);
    chk("reset pc",    bus.inst_pc,             32'd0);
    chk("reset busy",  {31'd0, bus.busy},       32'd0);
    chk("reset addr",  bus.imem_addr,           32'd0);
    rst = 1'b0;

    // Directed vectors: stream, stall/replay, redirect, halt/resume
    for (int i = 0; i < 15; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].ready, vecs[i].redir, vecs[i].rpc, vecs[i].halt);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_busy);
      chk($sformatf("vec%0d addr", i), bus.imem_addr, vecs[i].e_addr);
    end

    // Async reset during a stall with a live instruction
    @(negedge clk);
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus.inst_ready = 1'b0;
    @(negedge clk);
    #1 chk_out("stall pre", 1'b1, 32'd0, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("async valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("async out",   bus.inst_out,            32'd0);
    chk("async pc",    bus.inst_pc,             32'd0);
    chk("async busy",  {31'd0, bus.busy},       32'd0);
    chk("async addr",  bus.imem_addr,           32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    #1 chk_out("rst c0", 1'b0, 32'd0, 1'b0);
    @(negedge clk); #1 chk_out("rst c1", 1'b0, 32'd0, 1'b1);
    @(negedge clk); #1 chk_out("rst c2", 1'b1, 32'd0, 1'b1);
    @(negedge clk); #1 chk_out("rst c3", 1'b1, 32'd1, 1'b1);

    // Narrow PC wraps 15 -> 0 -> 1; also confirms RESET_PC
    @(negedge clk);
    rst4 = 1'b0;
    bus4.redirect_valid = 1'b1;
    bus4.redirect_pc    = 4'd15;
    #1 chk("w4 reset addr", {28'd0, bus4.imem_addr}, 32'd3);
    @(negedge clk);
    bus4.redirect_valid = 1'b0;
    #1 chk("w4 c1 addr", {28'd0, bus4.imem_addr}, 32'd15);
    chk("w4 c1 valid", {31'd0, bus4.inst_valid}, 32'd0);
    @(negedge clk);
    #1 chk("w4 c2 addr", {28'd0, bus4.imem_addr}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("w4 seq%0d valid", k), {31'd0, bus4.inst_valid}, 32'd1);
      chk($sformatf("w4 seq%0d pc", k), {28'd0, bus4.inst_pc}, (k == 0) ? 32'd15 : 32'(k - 1));
      chk($sformatf("w4 seq%0d out", k), bus4.inst_out, word_of((k == 0) ? 32'd15 : 32'(k - 1)));
    end

    // Random stimulus against a queue-level scoreboard
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_next = 32'd0;
    h = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c != 0) @(negedge clk);
      r   = ($urandom_range(9) < 7);
      rd  = ($urandom_range(24) == 0);
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(1))) : $urandom;
      if ($urandom_range(11) == 0) h = ~h;
      drive(r, rd, rpc, h);
      #1;
      has_buf  = (mq.size() > 0) && mq[0].cap;
      has_pend = (mq.size() > 0) && !mq[mq.size()-1].cap;
      e_addr   = (has_pend && has_buf && !r) ? mq[mq.size()-1].pc : m_next;
      chk_out($sformatf("rnd%0d", c), has_buf, has_buf ? mq[0].pc : 32'd0, mq.size() > 0);
      chk($sformatf("rnd%0d addr", c), bus.imem_addr, e_addr);
      if (rd) begin
        mq.delete();
        m_next = rpc;
      end else begin
        if (has_buf && r) void'(mq.pop_front());
        if (mq.size() > 0 && !mq[0].cap) mq[0].cap = 1'b1;
        if (!(mq.size() > 0 && !mq[mq.size()-1].cap) && !h) begin
          mq.push_back('{m_next, 1'b0});
          m_next = m_next + 32'd1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer in front of the synchronous word-addressed instruction memory (1-cycle read latency, re-reads `addr` on every `clk` posedge).
- Owns the program counter and issues one fetch per cycle.
- Replays the in-flight address when decode back-pressures, and flushes on branch/jump redirect.
- Delivers (instruction, pc) pairs to decode over a valid/ready handshake.

Parameters:
- ADDR_W, 32, width of PC and memory address (word address, not byte).
- RESET_PC, 0, first word fetched after reset.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  ADDR_W  word address to instruction memory; combinational (see Behaviour).
- imem_data  input  32  memory read data; valid the cycle after `imem_addr` was held across a posedge.
- inst_valid  output  1  registered; `inst_out`/`inst_pc` hold a live instruction.
- inst_ready  input  1  decode accepts when `inst_valid && inst_ready` at posedge.
- inst_out  output  32  registered instruction word.
- inst_pc  output  ADDR_W  registered word address of `inst_out`.
- redirect_valid  input  1  branch/jump taken; wins over everything.
- redirect_pc  input  ADDR_W  new fetch address.
- halt  input  1  stop issuing new fetches; buffered work still drains.
- busy  output  1  `pend || inst_valid`.

Behaviour:
- State:
  - fetch_pc: next address to issue.
  - pend: a read was issued at the last posedge and imem_data now holds it.
  - pend_pc: address of that read.
  - Output buffer: inst_valid, inst_out, inst_pc.
- Implicit occupancy states: EMPTY (!pend, !inst_valid), PEND, FULL, PEND+FULL.
- Reset (async, any time, including mid-stall or mid-redirect):
  - fetch_pc = RESET_PC.
  - pend = 0, pend_pc = 0.
  - inst_valid = 0, inst_out = 0, inst_pc = 0.
  - busy = 0.
- accept (combinational) = pend && (!inst_valid || inst_ready).
- imem_addr (combinational) = (pend && !accept) ? pend_pc : fetch_pc. This replays the stalled word so the memory re-presents it next cycle; no data loss.
- Posedge priority:
  1. redirect_valid:
     - fetch_pc <= redirect_pc.
     - pend <= 0 (in-flight word discarded).
     - inst_valid <= 0, even if inst_ready is high that cycle; the handshake does not complete.
     - The first word from the new path appears 2 posedges later.
  2. Else, output side:
     - If accept: inst_valid <= 1, inst_out <= imem_data, inst_pc <= pend_pc.
     - Else if inst_valid && inst_ready: inst_valid <= 0.
  3. Else, issue side:
     - If pend && !accept: pend stays 1 and pend_pc is unchanged (replay).
     - Else if !halt: pend <= 1, pend_pc <= fetch_pc, fetch_pc <= fetch_pc + 1.
     - Else: pend <= 0.
- Latency and throughput:
  - Reset release to first inst_valid: 2 posedges (issue, then capture).
  - Sustained throughput: 1 instruction per cycle while inst_ready = 1.
- Wrap: fetch_pc + 1 is modulo 2^ADDR_W; all-ones wraps to 0 silently.
- Simultaneous halt + redirect: redirect loads the PC and halt blocks issue on later cycles. No fetch occurs until halt drops.
- Halt mid-stream: the pending word and the buffer drain normally. busy falls once both are empty.
- Instruction contents are not interpreted; 0x00000000 (nop) is forwarded like any other word.

Decomposition:
- Shared package/header: ADDR_W default and RESET_PC default, in a cpu-wide defines file guarded like other headers.
- No sub-module; the output buffer is a few lines. A single module is natural.

Test Plan:
- Memory 0:00000000, 1:34020026, 2:34030034, 3:00628020; rst pulse, inst_ready=1 -> inst_valid from 2nd posedge after release; pc 0,1,2,3 with matching words, one per cycle.
- inst_ready=0 for 3 cycles while inst_pc=1 -> inst_out stays 34020026; imem_addr held at 2; on ready, pc 2 (34030034) delivered next cycle, nothing skipped or duplicated.
- redirect_valid with redirect_pc=4 while inst_pc=2 is valid -> inst_valid=0 next cycle; the in-flight word for pc 3 is dropped; pc 4 (ae020001) appears 2 posedges after redirect.
- halt=1 at pc 3 issue -> words up to the last issued pc are delivered, then inst_valid=0 and busy=0; halt=0 resumes at the next sequential pc.
- ADDR_W=4, redirect_pc=15 -> delivered pc sequence 15, 0, 1.
- Assert rst during a stall with inst_valid=1 -> all outputs 0 immediately (asynchronous); after release, fetch restarts at RESET_PC.
